// File: rtl/comp_mul_pipe.sv
// Three-stage signed fixed-point complex multiplier with valid/ready flow control,
// per-sample conjugate mode, optional round-half-up, and saturate-or-wrap output with overflow flag.
module comp_mul_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_FRAC_BIT = 30,
  parameter int ROUND        = 1,
  parameter int SAT          = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [2*DATA_WIDTH-1:0]   i_num_0,
  input  logic [2*DATA_WIDTH-1:0]   i_num_1,
  input  logic                      i_conj,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*DATA_WIDTH-1:0]   o_res,
  output logic                      o_sat
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W;
  localparam int SW = PW + 1;
  localparam int EW = PW + 2;

  localparam logic signed [EW-1:0] ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] RND_K = ONE <<< (NUM_FRAC_BIT - 1);
  localparam logic signed [EW-1:0] MAXV  = (ONE <<< (W - 1)) - ONE;
  localparam logic signed [EW-1:0] MINV  = -(ONE <<< (W - 1));

  function automatic logic signed [PW-1:0] mul_full(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = PW'(x);
    ye = PW'(y);
    return xe * ye;
  endfunction

  function automatic logic signed [EW-1:0] round_shift(input logic signed [SW-1:0] x);
    logic signed [EW-1:0] xe;
    xe = EW'(x);
    if (ROUND != 0) xe = xe + RND_K;
    return xe >>> NUM_FRAC_BIT;
  endfunction

  function automatic logic out_of_range(input logic signed [EW-1:0] x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic logic [W-1:0] reduce(input logic signed [EW-1:0] x);
    logic [W-1:0] r;
    r = x[W-1:0];
    if (SAT != 0) begin
      if (x > MAXV) r = MAXV[W-1:0];
      else if (x < MINV) r = MINV[W-1:0];
    end
    return r;
  endfunction

  logic signed [W-1:0]  a_re, a_im, b_re, b_im;
  logic                 en;

  logic                 vld_p1_q, conj_p1_q;
  logic signed [PW-1:0] rr_p1_q, ii_p1_q, ri_p1_q, ir_p1_q;
  logic signed [PW-1:0] rr_p1_d, ii_p1_d, ri_p1_d, ir_p1_d;

  logic                 vld_p2_q;
  logic signed [SW-1:0] re_p2_q, im_p2_q;
  logic signed [SW-1:0] re_p2_d, im_p2_d;

  logic                 vld_p3_q, sat_p3_q;
  logic [W-1:0]         re_p3_q, im_p3_q;
  logic                 sat_p3_d;
  logic [W-1:0]         re_p3_d, im_p3_d;
  logic signed [EW-1:0] re_sh, im_sh;

  assign a_re = i_num_0[PW-1:W];
  assign a_im = i_num_0[W-1:0];
  assign b_re = i_num_1[PW-1:W];
  assign b_im = i_num_1[W-1:0];

  // Whole pipe advances together; o_ready is combinational from i_ready.
  assign en      = !vld_p3_q || i_ready;
  assign o_ready = en;

  // S1: four full-precision partial products
  always_comb begin
    rr_p1_d = mul_full(a_re, b_re);
    ii_p1_d = mul_full(a_im, b_im);
    ri_p1_d = mul_full(a_re, b_im);
    ir_p1_d = mul_full(a_im, b_re);
  end

  // S2: lossless combine; conj flips the sign of the cross terms
  always_comb begin
    if (conj_p1_q) begin
      re_p2_d = SW'(rr_p1_q) + SW'(ii_p1_q);
      im_p2_d = SW'(ir_p1_q) - SW'(ri_p1_q);
    end else begin
      re_p2_d = SW'(rr_p1_q) - SW'(ii_p1_q);
      im_p2_d = SW'(ri_p1_q) + SW'(ir_p1_q);
    end
  end

  // S3: round, rescale, reduce; overflow only reported for real samples
  always_comb begin
    re_sh    = round_shift(re_p2_q);
    im_sh    = round_shift(im_p2_q);
    re_p3_d  = reduce(re_sh);
    im_p3_d  = reduce(im_sh);
    sat_p3_d = vld_p2_q && (out_of_range(re_sh) || out_of_range(im_sh));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      conj_p1_q <= 1'b0;
      rr_p1_q   <= '0;
      ii_p1_q   <= '0;
      ri_p1_q   <= '0;
      ir_p1_q   <= '0;
      vld_p2_q  <= 1'b0;
      re_p2_q   <= '0;
      im_p2_q   <= '0;
      vld_p3_q  <= 1'b0;
      sat_p3_q  <= 1'b0;
      re_p3_q   <= '0;
      im_p3_q   <= '0;
    end else if (en) begin
      vld_p1_q  <= i_valid;
      conj_p1_q <= i_conj;
      rr_p1_q   <= rr_p1_d;
      ii_p1_q   <= ii_p1_d;
      ri_p1_q   <= ri_p1_d;
      ir_p1_q   <= ir_p1_d;
      vld_p2_q  <= vld_p1_q;
      re_p2_q   <= re_p2_d;
      im_p2_q   <= im_p2_d;
      vld_p3_q  <= vld_p2_q;
      sat_p3_q  <= sat_p3_d;
      re_p3_q   <= re_p3_d;
      im_p3_q   <= im_p3_d;
    end
  end

  assign o_valid = vld_p3_q;
  assign o_sat   = sat_p3_q;
  assign o_res   = {re_p3_q, im_p3_q};

endmodule
